// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers hex digits from a multiplexed active-low 7-segment bus.
// Each digit commits only after anode settling and a run of identical legal decodes.
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int STABLE_COUNT  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seven_seg,
   input  logic [NUM_DIGITS-1:0]   anode,
   output logic [4*NUM_DIGITS-1:0] hex_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    update,
   output logic                    pattern_err,
   output logic                    anode_err
);
   localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
   localparam int MW = $clog2(STABLE_COUNT + 1);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam logic [4:0] BLANK = 5'd16;
   localparam logic [4:0] ILL   = 5'd31;

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

   state_t                  state, state_n;
   logic [6:0]              seg_r;
   logic [NUM_DIGITS-1:0]   an_r, an_prev, low;
   logic [SW-1:0]           settle_cnt, settle_n;
   logic [MW-1:0]           match_cnt, match_n;
   logic [4:0]              last_code, code_n, code;
   logic                    last_ill, ill_n;
   logic [IW-1:0]           sel, sel_n, idx;
   logic [4*NUM_DIGITS-1:0] hex_n;
   logic [NUM_DIGITS-1:0]   valid_n;
   logic                    upd_n, perr_n, aerr_n;
   logic [3:0]              nib;
   logic                    vld;

   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'b0000001: return 5'h0;
         7'b1001111: return 5'h1;
         7'b0010010: return 5'h2;
         7'b0000110: return 5'h3;
         7'b1001100: return 5'h4;
         7'b0100100: return 5'h5;
         7'b0100000: return 5'h6;
         7'b0001111: return 5'h7;
         7'b0000000: return 5'h8;
         7'b0000100: return 5'h9;
         7'b0001000: return 5'hA;
         7'b1100000: return 5'hB;
         7'b0110001: return 5'hC;
         7'b1000010: return 5'hD;
         7'b0110000: return 5'hE;
         7'b0111000: return 5'hF;
         7'b1111111, 7'b1111110: return BLANK;
         default: return ILL;
      endcase
   endfunction

   assign low  = ~an_r;
   assign code = decode(seg_r);
   assign nib  = code == BLANK ? 4'd0 : code[3:0];
   assign vld  = code != BLANK;

   always_comb begin
      idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) if (low[i]) idx = IW'(i);
   end

   always_comb begin
      state_n  = state;
      settle_n = settle_cnt;
      match_n  = match_cnt;
      code_n   = last_code;
      ill_n    = last_ill;
      sel_n    = sel;
      hex_n    = hex_out;
      valid_n  = digit_valid;
      upd_n    = 1'b0;
      perr_n   = 1'b0;
      aerr_n   = 1'b0;
      // an anode change overrides whatever the FSM was doing, including sampling
      if (an_r != an_prev) begin
         settle_n = '0;
         match_n  = '0;
         ill_n    = 1'b0;
         if (low == '0) state_n = IDLE;
         else if (!$onehot(low)) begin
            state_n = IDLE;
            aerr_n  = 1'b1;
         end else begin
            state_n = SETTLE_CYCLES == 0 ? SAMPLE : SETTLE;
            sel_n   = idx;
         end
      end else if (state == SETTLE) begin
         if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_n = SAMPLE;
         else settle_n = settle_cnt + 1'b1;
      end else if (state == SAMPLE) begin
         code_n = code;
         ill_n  = code == ILL;
         perr_n = code == ILL && !last_ill;
         if (code == ILL) match_n = '0;
         else if (match_cnt != '0 && code == last_code)
            match_n = match_cnt == MW'(STABLE_COUNT) ? match_cnt : match_cnt + 1'b1;
         else match_n = MW'(1);
         // commit on reaching the threshold, not while a saturated run continues
         if (code != ILL && match_n == MW'(STABLE_COUNT) &&
             !(match_cnt == MW'(STABLE_COUNT) && code == last_code)) begin
            hex_n[4*int'(sel) +: 4] = nib;
            valid_n[sel]            = vld;
            upd_n = hex_out[4*int'(sel) +: 4] != nib || digit_valid[sel] != vld;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         seg_r       <= '0;
         an_r        <= '0;
         an_prev     <= '0;
         settle_cnt  <= '0;
         match_cnt   <= '0;
         last_code   <= '0;
         last_ill    <= 1'b0;
         sel         <= '0;
         hex_out     <= '0;
         digit_valid <= '0;
         update      <= 1'b0;
         pattern_err <= 1'b0;
         anode_err   <= 1'b0;
      end else begin
         state       <= state_n;
         seg_r       <= seven_seg;
         an_r        <= anode;
         an_prev     <= an_r;
         settle_cnt  <= settle_n;
         match_cnt   <= match_n;
         last_code   <= code_n;
         last_ill    <= ill_n;
         sel         <= sel_n;
         hex_out     <= hex_n;
         digit_valid <= valid_n;
         update      <= upd_n;
         pattern_err <= perr_n;
         anode_err   <= aerr_n;
      end
   end
endmodule
